// File: rtl/flow_rank_store_if.sv
// flow_rank_store_if: push/pop/status bundle between the PIFO classifier,
// the scheduler tree and flow_rank_store.
//
// Request semantics: push and pop are single-cycle requests with no ready
// signal. A push is either taken in the cycle it is asserted or rejected,
// and a rejection is reported by push_drop one cycle later. A pop
// returns its entry one cycle later, qualified by a one-cycle pop_valid
// pulse. When pop_valid is low, pop_rank/pop_value keep their last contents.
// The scheduler uses flow_empty/flow_count to avoid useless pops.
interface flow_rank_store_if #(
  parameter int FLOWS   = 10,
  parameter int DEPTH   = 16,
  parameter int RANK_W  = 32,
  parameter int VALUE_W = 32
);
  localparam int FW = $clog2(FLOWS);
  localparam int CW = $clog2(DEPTH + 1);

  logic                      push;
  logic [FW-1:0]             push_flow;
  logic [RANK_W-1:0]         push_rank;
  logic [VALUE_W-1:0]        push_value;
  logic                      push_drop;

  logic                      pop;
  logic [FW-1:0]             pop_flow;
  logic [RANK_W-1:0]         pop_rank;
  logic [VALUE_W-1:0]        pop_value;
  logic                      pop_valid;

  logic [FLOWS-1:0]          flow_empty;
  logic [FLOWS-1:0]          flow_full;
  logic [FLOWS*CW-1:0]       flow_count;
  logic [FLOWS*RANK_W-1:0]   head_rank;

  // Classifier/scheduler side
  modport master (
    output push, push_flow, push_rank, push_value, pop, pop_flow,
    input  push_drop, pop_rank, pop_value, pop_valid,
    input  flow_empty, flow_full, flow_count, head_rank
  );

  // Store side
  modport slave (
    input  push, push_flow, push_rank, push_value, pop, pop_flow,
    output push_drop, pop_rank, pop_value, pop_valid,
    output flow_empty, flow_full, flow_count, head_rank
  );
endinterface

// File: rtl/flow_rank_store.sv
// flow_rank_store: per-flow circular FIFO store of (rank, value) pairs.
// Binary flow select on push and pop, per-flow occupancy and status,
// registered drop signalling, and an empty-flow bypass when a push and a
// pop hit the same empty flow in one cycle.
//
// Build option: define FLOW_RANK_STORE_PEEK_EN to drive head_rank with the
// rank at the head of every flow; without it head_rank is tied to zero and
// no per-flow head read mux is built.
module flow_rank_store #(
  parameter int FLOWS   = 10,
  parameter int DEPTH   = 16,
  parameter int RANK_W  = 32,
  parameter int VALUE_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  flow_rank_store_if.slave     bus
);

  localparam int FW = $clog2(FLOWS);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Storage (never reset) and per-flow control state
  logic [RANK_W-1:0]  r_rank_mem  [FLOWS][DEPTH];
  logic [VALUE_W-1:0] r_value_mem [FLOWS][DEPTH];
  logic [PW-1:0]      r_head      [FLOWS];
  logic [PW-1:0]      r_tail      [FLOWS];
  logic [CW-1:0]      r_count     [FLOWS];

  // Registered pop result and drop pulse
  logic               r_pop_valid;
  logic [RANK_W-1:0]  r_pop_rank;
  logic [VALUE_W-1:0] r_pop_value;
  logic               r_push_drop;

  // Per-flow decode
  logic [FLOWS-1:0]   w_push_sel;
  logic [FLOWS-1:0]   w_pop_sel;
  logic [FLOWS-1:0]   w_empty;
  logic [FLOWS-1:0]   w_full;
  logic [FLOWS-1:0]   w_pop_ok;
  logic [FLOWS-1:0]   w_bypass;
  logic [FLOWS-1:0]   w_push_acc;
  logic [FLOWS-1:0]   w_push_ok;

  // Next-state of the pop result registers
  logic               w_pop_any;
  logic [RANK_W-1:0]  w_pop_rank_nxt;
  logic [VALUE_W-1:0] w_pop_value_nxt;
  logic               w_push_drop_nxt;

  // Packed status views
  logic [FLOWS*CW-1:0]     w_flow_count;
  logic [FLOWS*RANK_W-1:0] w_head_rank;

  // Decode requests per flow. An out-of-range flow index matches no flow,
  // which makes such a push a drop and such a pop invalid.
  always_comb begin
    w_push_sel = '0;
    w_pop_sel  = '0;
    w_empty    = '0;
    w_full     = '0;
    for (int f = 0; f < FLOWS; f++) begin
      w_push_sel[f] = bus.push && (bus.push_flow == FW'(f));
      w_pop_sel[f]  = bus.pop  && (bus.pop_flow  == FW'(f));
      w_empty[f]    = (r_count[f] == '0);
      w_full[f]     = (r_count[f] == FULL_COUNT);
    end
  end

  // Classify each flow's activity this cycle. A full flow still takes a
  // push when the same cycle pops it, because the pop frees the slot the
  // push writes. A push+pop on an empty flow bypasses storage entirely.
  always_comb begin
    w_pop_ok   = w_pop_sel & ~w_empty;
    w_bypass   = w_push_sel & w_pop_sel & w_empty;
    w_push_acc = w_push_sel & (~w_full | w_pop_sel);
    w_push_ok  = w_push_acc & ~w_bypass;
  end

  // Select the pop result: bypass data, the head entry, or hold.
  always_comb begin
    w_pop_any       = |(w_pop_ok | w_bypass);
    w_pop_rank_nxt  = r_pop_rank;
    w_pop_value_nxt = r_pop_value;
    for (int f = 0; f < FLOWS; f++) begin
      if (w_bypass[f]) begin
        w_pop_rank_nxt  = bus.push_rank;
        w_pop_value_nxt = bus.push_value;
      end else if (w_pop_ok[f]) begin
        w_pop_rank_nxt  = r_rank_mem[f][r_head[f]];
        w_pop_value_nxt = r_value_mem[f][r_head[f]];
      end
    end
  end

  // A push is dropped when no flow accepted it.
  always_comb begin
    w_push_drop_nxt = bus.push && !(|w_push_acc);
  end

  // Write accepted pushes at the tail. On a full flow with a same-cycle pop
  // the tail equals the head, but the head entry has already been read
  // combinationally above, so the overwrite is safe.
  always_ff @(posedge clk) begin
    for (int f = 0; f < FLOWS; f++) begin
      if (w_push_ok[f]) begin
        r_rank_mem[f][r_tail[f]]  <= bus.push_rank;
        r_value_mem[f][r_tail[f]] <= bus.push_value;
      end
    end
  end

  // Advance pointers and occupancy per flow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < FLOWS; f++) begin
        r_head[f]  <= '0;
        r_tail[f]  <= '0;
        r_count[f] <= '0;
      end
    end else begin
      for (int f = 0; f < FLOWS; f++) begin
        if (w_push_ok[f]) begin
          r_tail[f] <= r_tail[f] + 1'b1;
        end
        if (w_pop_ok[f]) begin
          r_head[f] <= r_head[f] + 1'b1;
        end
        if (w_push_ok[f] && !w_pop_ok[f]) begin
          r_count[f] <= r_count[f] + 1'b1;
        end else if (w_pop_ok[f] && !w_push_ok[f]) begin
          r_count[f] <= r_count[f] - 1'b1;
        end
      end
    end
  end

  // Register the pop result and the drop pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pop_valid <= 1'b0;
      r_pop_rank  <= '0;
      r_pop_value <= '0;
      r_push_drop <= 1'b0;
    end else begin
      r_pop_valid <= w_pop_any;
      r_pop_rank  <= w_pop_rank_nxt;
      r_pop_value <= w_pop_value_nxt;
      r_push_drop <= w_push_drop_nxt;
    end
  end

  // Pack per-flow occupancy.
  always_comb begin
    w_flow_count = '0;
    for (int f = 0; f < FLOWS; f++) begin
      w_flow_count[f*CW +: CW] = r_count[f];
    end
  end

`ifdef FLOW_RANK_STORE_PEEK_EN
  // Expose each flow's head rank; meaningful only while the flow is non-empty.
  always_comb begin
    w_head_rank = '0;
    for (int f = 0; f < FLOWS; f++) begin
      w_head_rank[f*RANK_W +: RANK_W] = r_rank_mem[f][r_head[f]];
    end
  end
`else
  // Peek disabled: no head read mux.
  always_comb begin
    w_head_rank = '0;
  end
`endif

  assign bus.pop_valid  = r_pop_valid;
  assign bus.pop_rank   = r_pop_rank;
  assign bus.pop_value  = r_pop_value;
  assign bus.push_drop  = r_push_drop;
  assign bus.flow_empty = w_empty;
  assign bus.flow_full  = w_full;
  assign bus.flow_count = w_flow_count;
  assign bus.head_rank  = w_head_rank;

endmodule

// File: tb/tb_flow_rank_store.sv
// tb_flow_rank_store: table-driven vectors plus hand sequences for
// flow_rank_store; popped entries are checked against an expected queue.
module tb_flow_rank_store;

  localparam int FLOWS   = 10;
  localparam int DEPTH   = 16;
  localparam int RANK_W  = 32;
  localparam int VALUE_W = 32;
  localparam int FW      = 4;
  localparam int CW      = 5;
  localparam int W       = RANK_W + VALUE_W;
  localparam logic [31:0] VMASK = 32'h5A5A_5A5A;

  typedef struct {
    logic              pu;
    logic [FW-1:0]     pf;
    logic [RANK_W-1:0] pr;
    logic              po;
    logic [FW-1:0]     qf;
    logic              ev;   // expected pop_valid
    logic [RANK_W-1:0] er;   // expected pop_rank when valid
    logic              ed;   // expected push_drop
    logic [FW-1:0]     cf;   // flow whose count is checked
    logic [CW-1:0]     ec;   // expected count of that flow
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flow_rank_store_if #(.FLOWS(FLOWS), .DEPTH(DEPTH), .RANK_W(RANK_W), .VALUE_W(VALUE_W)) bus ();

  flow_rank_store #(.FLOWS(FLOWS), .DEPTH(DEPTH), .RANK_W(RANK_W), .VALUE_W(VALUE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0]      exp_q[$];
  logic [RANK_W-1:0] last_rank;
  logic [W-1:0]      mon_e;
  logic [RANK_W-1:0] fifo0[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [CW-1:0] cnt(input int f);
    return bus.flow_count[f*CW +: CW];
  endfunction

  // Every pop_valid pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && bus.pop_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop_valid", 64'(bus.pop_rank), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("pop_rank",  64'(bus.pop_rank),  64'(mon_e[W-1:VALUE_W]));
        check("pop_value", 64'(bus.pop_value), 64'(mon_e[VALUE_W-1:0]));
      end
    end
  end

  // ---------------- driver ----------------
  function automatic vec_t mk(input logic pu, input logic [FW-1:0] pf, input logic [31:0] pr,
                              input logic po, input logic [FW-1:0] qf, input logic ev,
                              input logic [31:0] er, input logic ed, input logic [FW-1:0] cf,
                              input logic [CW-1:0] ec);
    vec_t v;
    v.pu = pu; v.pf = pf; v.pr = pr; v.po = po; v.qf = qf;
    v.ev = ev; v.er = er; v.ed = ed; v.cf = cf; v.ec = ec;
    return v;
  endfunction

  // Called at a falling edge: drive one cycle, then check at the next one.
  task automatic apply(input vec_t v, input string tag);
    bus.push       = v.pu;
    bus.push_flow  = v.pf;
    bus.push_rank  = v.pr;
    bus.push_value = v.pr ^ VMASK;
    bus.pop        = v.po;
    bus.pop_flow   = v.qf;
    if (v.ev) begin
      exp_q.push_back({v.er, v.er ^ VMASK});
      last_rank = v.er;
    end
    @(negedge clk);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    check({tag, ".pop_valid"}, 64'(bus.pop_valid), 64'(v.ev));
    check({tag, ".push_drop"}, 64'(bus.push_drop), 64'(v.ed));
    check({tag, ".count"},     64'(cnt(int'(v.cf))), 64'(v.ec));
    if (!v.ev) check({tag, ".rank_hold"}, 64'(bus.pop_rank), 64'(last_rank));
  endtask

  vec_t tbl[15];

  initial begin
    vec_t v;
    int   k;
    logic pu, po, pop_ok, byp, push_ok, ev, ed;
    logic [31:0] r, er;

    tbl[0]  = mk(1'b1, 4'd3,  32'd5,    1'b0, 4'd0,  1'b0, 32'd0,    1'b0, 4'd3, 5'd1);
    tbl[1]  = mk(1'b1, 4'd3,  32'd9,    1'b0, 4'd0,  1'b0, 32'd0,    1'b0, 4'd3, 5'd2);
    tbl[2]  = mk(1'b1, 4'd3,  32'd2,    1'b0, 4'd0,  1'b0, 32'd0,    1'b0, 4'd3, 5'd3);
    tbl[3]  = mk(1'b0, 4'd0,  32'd0,    1'b1, 4'd3,  1'b1, 32'd5,    1'b0, 4'd3, 5'd2);
    tbl[4]  = mk(1'b0, 4'd0,  32'd0,    1'b1, 4'd3,  1'b1, 32'd9,    1'b0, 4'd3, 5'd1);
    tbl[5]  = mk(1'b0, 4'd0,  32'd0,    1'b1, 4'd3,  1'b1, 32'd2,    1'b0, 4'd3, 5'd0);
    tbl[6]  = mk(1'b1, 4'd7,  32'hAB,   1'b1, 4'd7,  1'b1, 32'hAB,   1'b0, 4'd7, 5'd0);
    tbl[7]  = mk(1'b1, 4'd2,  32'd11,   1'b0, 4'd0,  1'b0, 32'd0,    1'b0, 4'd2, 5'd1);
    tbl[8]  = mk(1'b1, 4'd1,  32'd33,   1'b1, 4'd2,  1'b1, 32'd11,   1'b0, 4'd1, 5'd1);
    tbl[9]  = mk(1'b0, 4'd0,  32'd0,    1'b0, 4'd0,  1'b0, 32'd0,    1'b0, 4'd2, 5'd0);
    tbl[10] = mk(1'b0, 4'd0,  32'd0,    1'b1, 4'd10, 1'b0, 32'd0,    1'b0, 4'd1, 5'd1);
    tbl[11] = mk(1'b0, 4'd0,  32'd0,    1'b1, 4'd4,  1'b0, 32'd0,    1'b0, 4'd4, 5'd0);
    tbl[12] = mk(1'b1, 4'd10, 32'd77,   1'b0, 4'd0,  1'b0, 32'd0,    1'b1, 4'd1, 5'd1);
    tbl[13] = mk(1'b0, 4'd0,  32'd0,    1'b1, 4'd1,  1'b1, 32'd33,   1'b0, 4'd1, 5'd0);
    tbl[14] = mk(1'b1, 4'd15, 32'd1,    1'b0, 4'd0,  1'b0, 32'd0,    1'b1, 4'd0, 5'd0);

    // reset
    rst = 1'b1;
    bus.push = 1'b0; bus.push_flow = '0; bus.push_rank = '0; bus.push_value = '0;
    bus.pop = 1'b0;  bus.pop_flow = '0;
    last_rank = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset.flow_empty", 64'(bus.flow_empty), 64'h3FF);
    check("reset.flow_full",  64'(bus.flow_full),  64'h0);
    check("reset.flow_count", 64'(bus.flow_count), 64'h0);
    check("reset.pop_valid",  64'(bus.pop_valid),  64'h0);
    check("reset.push_drop",  64'(bus.push_drop),  64'h0);
    check("reset.pop_rank",   64'(bus.pop_rank),   64'h0);
    check("reset.pop_value",  64'(bus.pop_value),  64'h0);

    // table vectors
    for (int i = 0; i < 15; i++) apply(tbl[i], $sformatf("vec%0d", i));
    check("all_empty_after_table", 64'(bus.flow_empty), 64'h3FF);

    // fill flow 0 to DEPTH, then overflow
    for (int i = 0; i < DEPTH; i++) begin
      apply(mk(1'b1, 4'd0, 32'(100 + i), 1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 4'd0, CW'(i + 1)),
            $sformatf("fill%0d", i));
      fifo0.push_back(32'(100 + i));
    end
    check("full.flow_full",  64'(bus.flow_full),  64'h001);
    check("full.flow_empty", 64'(bus.flow_empty), 64'h3FE);
    apply(mk(1'b1, 4'd0, 32'd999, 1'b0, 4'd0, 1'b0, 32'd0, 1'b1, 4'd0, 5'd16), "overflow");

    // mixed push/pop on flow 0, mostly simultaneous, across pointer wrap
    for (int i = 0; i < 40; i++) begin
      k  = $urandom_range(0, 4);
      pu = (k != 1);
      po = (k != 0);
      r  = 32'(200 + i);
      pop_ok  = po && (fifo0.size() > 0);
      byp     = pu && po && (fifo0.size() == 0);
      push_ok = pu && ((fifo0.size() < DEPTH) || po);
      ev = pop_ok || byp;
      er = byp ? r : (pop_ok ? fifo0[0] : 32'd0);
      ed = pu && !push_ok;
      if (pop_ok) void'(fifo0.pop_front());
      if (push_ok && !byp) fifo0.push_back(r);
      apply(mk(pu, 4'd0, r, po, 4'd0, ev, er, ed, 4'd0, CW'(fifo0.size())),
            $sformatf("mix%0d", i));
    end

    // head-rank peek on flow 5
    apply(mk(1'b1, 4'd5, 32'd4, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 4'd5, 5'd1), "peek_push4");
    apply(mk(1'b1, 4'd5, 32'd8, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 4'd5, 5'd2), "peek_push8");
`ifdef FLOW_RANK_STORE_PEEK_EN
    check("head_rank5.first", 64'(bus.head_rank[5*RANK_W +: RANK_W]), 64'd4);
`else
    check("head_rank.tied",   64'(bus.head_rank[5*RANK_W +: RANK_W]), 64'd0);
`endif
    apply(mk(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 1'b1, 32'd4, 1'b0, 4'd5, 5'd1), "peek_pop");
`ifdef FLOW_RANK_STORE_PEEK_EN
    check("head_rank5.second", 64'(bus.head_rank[5*RANK_W +: RANK_W]), 64'd8);
`else
    check("head_rank.tied2",   64'(bus.head_rank), 64'd0);
`endif

    // asynchronous reset in the middle of a burst on flow 6
    apply(mk(1'b1, 4'd6, 32'd50, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 4'd6, 5'd1), "burst0");
    apply(mk(1'b1, 4'd6, 32'd51, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 4'd6, 5'd2), "burst1");
    apply(mk(1'b1, 4'd6, 32'd52, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 4'd6, 5'd3), "burst2");
    bus.push = 1'b1; bus.push_flow = 4'd6; bus.push_rank = 32'd53; bus.push_value = 32'd53 ^ VMASK;
    bus.pop  = 1'b1; bus.pop_flow  = 4'd6;
    exp_q.push_back({32'd50, 32'd50 ^ VMASK});
    @(posedge clk);
    #2;
    bus.push = 1'b0; bus.pop = 1'b0;
    check("midburst.pop_valid", 64'(bus.pop_valid), 64'd1);
    check("midburst.count6",    64'(cnt(6)),        64'd3);
    rst = 1'b1;
    #1;
    check("async_rst.flow_count", 64'(bus.flow_count), 64'h0);
    check("async_rst.pop_valid",  64'(bus.pop_valid),  64'h0);
    check("async_rst.flow_empty", 64'(bus.flow_empty), 64'h3FF);
    check("async_rst.pop_rank",   64'(bus.pop_rank),   64'h0);
    exp_q.delete();
    last_rank = '0;
    @(negedge clk);
    rst = 1'b0;
    apply(mk(1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 1'b0, 32'd0, 1'b0, 4'd6, 5'd0), "post_rst_pop");

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
